pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined shifter unit for the CPU execute path. It supports logical, arithmetic and rotate shifts of a WIDTH-bit operand, with a carry flag plus N and Z flags.
- One log2 shift stage per pipeline register; valid/ready handshake with full backpressure.
- Sits between operand select and the ALU result mux; FS uses the same encoding as the ALU function select.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/shift_stage.sv | 92 +++++++++
 rtl/pipelined_barrel_shifter.sv | 72 +++++++
 tb/tb_pipelined_barrel_shifter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared execute-path definitions: shifter function-select codes and fill helper.
package cpu_pkg;

    // Function-select codes (same encoding as the ALU function select)
    localparam logic [4:0] FS_SLL = 5'h0C;
    localparam logic [4:0] FS_SRL = 5'h0D;
    localparam logic [4:0] FS_SRA = 5'h0E;
    localparam logic [4:0] FS_ROL = 5'h0F;
    localparam logic [4:0] FS_ROR = 5'h10;

    // Bit shifted in at the top on a right shift: sign for SRA, zero otherwise.
    // Every SRA stage refills with the current MSB, so the original sign
    // propagates through the whole chain.
    function automatic logic fill_bit(input logic [4:0] fs, input logic msb);
        return (fs == FS_SRA) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One log2 stage of the shifter: conditional shift by 2^K, carry update,
// and a single pipeline register with valid/ready backpressure.
module shift_stage
    import cpu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int K     = 0,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    // upstream side
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             carry_i,
    input  logic [4:0]       fs_i,
    input  logic [SHW-1:0]   shamt_i,   // bit 0 is this stage's shift bit
    // downstream side
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o,
    output logic [4:0]       fs_o,
    output logic [SHW-1:0]   shamt_o
);

    localparam int S = 1 << K;

    logic             vld_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic             carry_d, carry_q;
    logic [4:0]       fs_q;
    logic [SHW-1:0]   shamt_q;
    logic             fill;

    assign fill = fill_bit(fs_i, data_i[WIDTH-1]);

    // Shift by 2^K when this stage's SHAMT bit is set; carry keeps the last bit pushed out
    always_comb begin
        data_d  = data_i;
        carry_d = carry_i;
        if (shamt_i[0]) begin
            case (fs_i)
                FS_SLL: begin
                    data_d  = {data_i[WIDTH-S-1:0], {S{1'b0}}};
                    carry_d = data_i[WIDTH-S];
                end
                FS_SRL, FS_SRA: begin
                    data_d  = {{S{fill}}, data_i[WIDTH-1:S]};
                    carry_d = data_i[S-1];
                end
                FS_ROL: begin
                    data_d  = {data_i[WIDTH-S-1:0], data_i[WIDTH-1:WIDTH-S]};
                    carry_d = data_i[WIDTH-S];
                end
                FS_ROR: begin
                    data_d  = {data_i[S-1:0], data_i[WIDTH-1:S]};
                    carry_d = data_i[S-1];
                end
                default: ;  // unsupported codes pass through untouched, carry stays 0
            endcase
        end
    end

    // Stage can take new contents when empty or when downstream is draining it
    assign ready_o = ~vld_q | ready_i;

    // Pipeline register: loads whenever ready, holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
            fs_q    <= '0;
            shamt_q <= '0;
        end else if (ready_o) begin
            vld_q   <= valid_i;
            data_q  <= data_d;
            carry_q <= carry_d;
            fs_q    <= fs_i;
            shamt_q <= shamt_i >> 1;    // next stage sees its bit at position 0
        end
    end

    assign valid_o = vld_q;
    assign data_o  = data_q;
    assign carry_o = carry_q;
    assign fs_o    = fs_q;
    assign shamt_o = shamt_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW shift stages chained with valid/ready,
// producing SHFT_OUT plus C/N/Z flags for the ALU result mux.
module pipelined_barrel_shifter
    import cpu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,      // async, active low
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [4:0]       FS,
    input  logic [SHW-1:0]   SHAMT,
    input  logic [WIDTH-1:0] T,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SHFT_OUT,
    output logic             C,
    output logic             N,
    output logic             Z
);

    // Index k is the input of stage k; index SHW is the final register
    logic [SHW:0]            vld_pipe;
    logic [SHW:0]            rdy_p;
    logic [SHW:0]            carry_p;
    logic [SHW:0][WIDTH-1:0] data_p;
    logic [SHW:0][4:0]       fs_p;
    logic [SHW:0][SHW-1:0]   sh_p;

    assign vld_pipe[0] = IN_VALID;
    assign data_p[0]   = T;
    assign carry_p[0]  = 1'b0;
    assign fs_p[0]     = FS;
    assign sh_p[0]     = SHAMT;
    assign rdy_p[SHW]  = OUT_READY;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (reset),
            .valid_i (vld_pipe[k]),
            .ready_o (rdy_p[k]),
            .data_i  (data_p[k]),
            .carry_i (carry_p[k]),
            .fs_i    (fs_p[k]),
            .shamt_i (sh_p[k]),
            .valid_o (vld_pipe[k+1]),
            .ready_i (rdy_p[k+1]),
            .data_o  (data_p[k+1]),
            .carry_o (carry_p[k+1]),
            .fs_o    (fs_p[k+1]),
            .shamt_o (sh_p[k+1])
        );
    end

    // Function code and leftover shift bits are spent by the last stage
    logic unused_tail;
    assign unused_tail = ^{fs_p[SHW], sh_p[SHW]};

    assign IN_READY  = rdy_p[0];
    assign OUT_VALID = vld_pipe[SHW];
    assign SHFT_OUT  = data_p[SHW];
    assign C         = carry_p[SHW];
    assign N         = data_p[SHW][WIDTH-1];
    assign Z         = (data_p[SHW] == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed vector table, random in-order stream with a
// mid-stream stall, async reset with ops in flight, and an 8-bit build.
module tb_pipelined_barrel_shifter;

    logic        clk;
    logic        rst_n;
    // 32-bit instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  fs, shamt;
    logic [31:0] t, shft;
    logic        c, n, z;
    // 8-bit instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [4:0]  fs8;
    logic [2:0]  shamt8;
    logic [7:0]  t8, shft8;
    logic        c8, n8, z8;

    int checks = 0;
    int errors = 0;

    pipelined_barrel_shifter #(.WIDTH(32)) dut (
        .clk(clk), .reset(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .FS(fs), .SHAMT(shamt), .T(t),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SHFT_OUT(shft), .C(c), .N(n), .Z(z)
    );

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_n),
        .IN_VALID(in_valid8), .IN_READY(in_ready8),
        .FS(fs8), .SHAMT(shamt8), .T(t8),
        .OUT_VALID(out_valid8), .OUT_READY(out_ready8),
        .SHFT_OUT(shft8), .C(c8), .N(n8), .Z(z8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole-operand shift of T by SHAMT, carry = last bit pushed out
    function automatic logic [32:0] model(input logic [4:0] f, input logic [4:0] sh,
                                          input logic [31:0] tv);
        logic [63:0] dbl;
        logic [31:0] o;
        logic        cy;
        int          s;
        s   = int'(sh);
        dbl = {tv, tv};
        o   = tv;
        cy  = 1'b0;
        case (f)
            5'h0C: begin o = tv << s; if (s != 0) cy = tv[32-s]; end
            5'h0D: begin o = tv >> s; if (s != 0) cy = tv[s-1]; end
            5'h0E: begin o = 32'($signed(tv) >>> s); if (s != 0) cy = tv[s-1]; end
            5'h0F: begin dbl = dbl << s; o = dbl[63:32]; if (s != 0) cy = o[0]; end
            5'h10: begin dbl = dbl >> s; o = dbl[31:0];  if (s != 0) cy = o[31]; end
            default: ;
        endcase
        return {cy, o};
    endfunction

    // Single op on the 32-bit unit; lat = edges from accept edge to OUT_VALID
    task automatic run_op32(input logic [4:0] f, input logic [4:0] sh, input logic [31:0] tv,
                            output logic [31:0] o, output logic co, no, zo, output int lat);
        @(negedge clk);
        fs = f; shamt = sh; t = tv; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        o = shft; co = c; no = n; zo = z;
    endtask

    task automatic run_op8(input logic [4:0] f, input logic [2:0] sh, input logic [7:0] tv,
                           output logic [7:0] o, output logic co, output int lat);
        @(negedge clk);
        fs8 = f; shamt8 = sh; t8 = tv; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid8 = 1'b0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        o = shft8; co = c8;
    endtask

    typedef struct {
        string       name;
        logic [4:0]  f;
        logic [4:0]  sh;
        logic [31:0] tv;
        logic [31:0] o;
        logic        co, no, zo;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] o;
        logic [7:0]  o8;
        logic        co, no, zo;
        int          lat;
        logic [4:0]  sfs[10];
        logic [4:0]  ssh[10];
        logic [31:0] st[10];
        logic [32:0] expq[$];
        logic [32:0] ex;
        logic [32:0] held;
        logic        held_v, saw_full, stale;
        int          sent, got, cyc;

        vt[0] = '{"sll1",     5'h0C, 5'd1,  32'h8000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vt[1] = '{"sra4",     5'h0E, 5'd4,  32'hF000_0010, 32'hFF00_0001, 1'b0, 1'b1, 1'b0};
        vt[2] = '{"sra31",    5'h0E, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vt[3] = '{"ror1",     5'h10, 5'd1,  32'h0000_0003, 32'h8000_0001, 1'b1, 1'b1, 1'b0};
        vt[4] = '{"rol1",     5'h0F, 5'd1,  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
        vt[5] = '{"unsup",    5'h00, 5'd7,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
        vt[6] = '{"sll0",     5'h0C, 5'd0,  32'h8000_0005, 32'h8000_0005, 1'b0, 1'b1, 1'b0};
        vt[7] = '{"srl_zero", 5'h0D, 5'd1,  32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        // Reset state, before any clock edge
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; fs = '0; shamt = '0; t = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; fs8 = '0; shamt8 = '0; t8 = '0;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_shft", shft, 32'h0);
        chk("rst_c", c, 1'b0);
        chk("rst_n_flag", n, 1'b0);
        chk("rst_z", z, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op32(vt[i].f, vt[i].sh, vt[i].tv, o, co, no, zo, lat);
            chk({vt[i].name, "_lat"}, lat, 5);
            chk({vt[i].name, "_out"}, o, vt[i].o);
            chk({vt[i].name, "_c"}, co, vt[i].co);
            chk({vt[i].name, "_n"}, no, vt[i].no);
            chk({vt[i].name, "_z"}, zo, vt[i].zo);
        end

        // Random back-to-back stream with a 3-cycle output stall
        for (int i = 0; i < 10; i++) begin
            int pick;
            pick   = int'($urandom_range(0, 5));
            sfs[i] = (pick == 5) ? 5'h03 : 5'(5'h0C + pick);
            ssh[i] = 5'($urandom_range(0, 31));
            st[i]  = $urandom;
        end
        sent = 0; got = 0; cyc = 0; saw_full = 1'b0; held_v = 1'b0; held = '0;
        while (got < 10 && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 7 && cyc < 10);
            in_valid  = (sent < 10);
            if (sent < 10) begin
                fs = sfs[sent]; shamt = ssh[sent]; t = st[sent];
            end
            #1;
            if (out_valid) begin
                if (held_v) chk("stall_hold", {c, shft}, held);
                if (out_ready) begin
                    if (expq.size() == 0) begin
                        chk("stream_extra", 1'b1, 1'b0);
                    end else begin
                        ex = expq.pop_front();
                        chk("stream_out", shft, ex[31:0]);
                        chk("stream_c", c, ex[32]);
                        chk("stream_n", n, ex[31]);
                        chk("stream_z", z, (ex[31:0] == 32'h0));
                    end
                    got++;
                    held_v = 1'b0;
                end else begin
                    held   = {c, shft};
                    held_v = 1'b1;
                end
            end
            if (!in_ready) saw_full = 1'b1;
            if (in_valid && in_ready) begin
                expq.push_back(model(sfs[sent], ssh[sent], st[sent]));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", got, 10);
        chk("stream_in_ready_drop", saw_full, 1'b1);

        // Reset with three ops in flight, first one already at the output
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fs = 5'h0C; shamt = 5'(i + 1); t = 32'hA5A5_0000 + i; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        chk("inflight_reached_out", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_shft", shft, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("midrst_no_stale", stale, 1'b0);
        chk("midrst_ready_after", in_ready, 1'b1);

        // 8-bit build
        run_op8(5'h0D, 3'd7, 8'h81, o8, co, lat);
        chk("w8_srl_lat", lat, 3);
        chk("w8_srl_out", o8, 8'h01);
        chk("w8_srl_c", co, 1'b0);
        run_op8(5'h0E, 3'd7, 8'h80, o8, co, lat);
        chk("w8_sra_out", o8, 8'hFF);
        chk("w8_sra_c", co, 1'b0);
        run_op8(5'h10, 3'd3, 8'h04, o8, co, lat);
        chk("w8_ror_out", o8, 8'h80);
        chk("w8_ror_c", co, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
